apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB3 completer (slave) backing the APB2 slave-side address window with a small register memory.
- Sits on the far end of the APB bus from the transfer/READ_WRITE-driven bridge, whose write and read paths it services.
- Responds to psel/penable/pwrite/paddr/pwdata with pready/prdata/pslverr.
- Inserts a programmable number of wait states and flags out-of-range addresses.

Parameters:
- ADDR_WIDTH, 8: width of paddr.
- DATA_WIDTH, 8: width of pwdata/prdata.
- MEM_DEPTH, 64: number of storage words; valid addresses are 0..MEM_DEPTH-1, and MEM_DEPTH must be <= 2^ADDR_WIDTH.
- WAIT_STATES, 1: extra access-phase cycles before pready; legal range 0..15.

Ports:
- pclk, in, 1: bus clock; all logic on its rising edge.
- presetn, in, 1: synchronous, active-high reset, sampled on the pclk rising edge. The name follows the codebase's bus-reset naming; polarity is high-asserted.
- psel, in, 1: slave select.
- penable, in, 1: access-phase strobe.
- pwrite, in, 1: 1 = write, 0 = read.
- paddr, in, ADDR_WIDTH: transfer address.
- pwdata, in, DATA_WIDTH: write data.
- pready, out, 1: transfer completion (registered).
- prdata, out, DATA_WIDTH: read data (registered).
- pslverr, out, 1: error response (registered), valid only while pready=1.

Behaviour:
- Reset (presetn=1 at an edge): pready=0, prdata=0, pslverr=0, all memory words=0, wait counter=0, state=IDLE. Reset overrides any transfer in flight. No partial write commits. After reset deasserts, the first sampled setup phase is serviced normally.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with psel=1 and penable=0 (setup phase), latch paddr, pwrite and pwdata into internal registers.
  - Load the counter with WAIT_STATES.
  - If WAIT_STATES=0, go directly to RESP, driving outputs as below. Otherwise go to WAIT.
  - psel=1 with penable=1 seen in IDLE is a protocol error. It is ignored and the block stays in IDLE.
- WAIT:
  - Decrement the counter each edge while psel=1 and penable=1.
  - On the edge where the counter reaches 1, go to RESP.
- Entering RESP (registered at that edge):
  - Set pready=1.
  - In range (latched addr < MEM_DEPTH), read: prdata = mem[addr], pslverr=0.
  - In range, write: prdata unchanged, pslverr=0.
  - Out of range: pslverr=1, prdata=0 on reads, memory untouched.
- RESP (single cycle):
  - A write commits mem[addr] <= latched pwdata at the edge ending this cycle, only when in range.
  - Then pready=0 and pslverr=0, and the state returns to IDLE.
  - prdata holds its last value until the next read completes.
- Latency: pready is high in exactly the (WAIT_STATES+1)th access-phase cycle, for one cycle. Total transfer is WAIT_STATES+2 cycles including setup.
- Back-to-back: a new setup phase may arrive in the cycle immediately after RESP and is accepted from IDLE with no bubble.
- Abort: if psel=0 is sampled in WAIT, return to IDLE. pready stays 0 and no write commits.
- Inputs sampled in WAIT/RESP do not change the latched address or data. Only the setup-phase values are used.
- Read-after-write to the same address returns the newly written data on the following transfer.

Test Plan:
- Reset and idle: hold presetn=1 for 2 cycles, then release with no traffic. pready=0, prdata=0 and pslverr=0 throughout. A read of addr 0x05 returns 0x00.
- Write/read, WAIT_STATES=1: write 0xA5 to 0x10, then read 0x10. pready is high on the 2nd access cycle of each transfer, the read returns prdata=0xA5, and pslverr=0.
- Zero wait, back-to-back: with WAIT_STATES=0, run writes 0x01 to 0x00, 0x02 to 0x01 and 0x03 to 0x3F with no idle cycles between them, then read all three back. pready is high in the first access cycle each time, and the reads return 0x01, 0x02 and 0x03.
- Out of range: write 0x77 to 0x40 with MEM_DEPTH=64, then read 0x40. Both transfers complete with pready=1 and pslverr=1, the read returns prdata=0x00, and mem[0x00] is unchanged.
- Abort: with WAIT_STATES=3, start a write of 0xFF to 0x02 and drop psel in the 2nd access cycle. pready never asserts. A subsequent read of 0x02 returns the old value.
- Reset mid-transfer: with WAIT_STATES=3, assert presetn during WAIT of a write of 0x5A to 0x03. At the next edge all outputs are 0 and the state is IDLE. A subsequent read of 0x03 returns 0x00.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB3 completer backed by a small register memory. Every transfer is
//   stretched by WAIT_STATES access-phase cycles. Addresses at or above
//   MEM_DEPTH complete with pslverr=1 and leave the memory untouched.
//
// Ports
//   pclk     in   bus clock; all logic runs on its rising edge
//   presetn  in   synchronous reset, active HIGH despite the name
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [ADDR_WIDTH-1:0] transfer address
//   pwdata   in   [DATA_WIDTH-1:0] write data
//   pready   out  registered transfer completion, one cycle per transfer
//   prdata   out  [DATA_WIDTH-1:0] registered read data, holds until next read
//   pslverr  out  registered error response, meaningful only with pready
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            cnt;

  logic                  latch_en;
  logic                  cnt_dec;
  logic                  resp_en;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  resp_write;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  always_ff @(posedge pclk) begin
    if (presetn) state <= IDLE;
    else         state <= next_state;
  end

  // With zero wait states the response is produced straight from the setup
  // phase, so the response address/direction come from the bus rather than
  // from the latches, which only update at that same edge.
  always_comb begin
    next_state = state;
    latch_en   = 1'b0;
    cnt_dec    = 1'b0;
    resp_en    = 1'b0;
    resp_addr  = addr_q;
    resp_write = write_q;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          latch_en   = 1'b1;
          resp_addr  = paddr;
          resp_write = pwrite;
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            resp_en    = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          next_state = IDLE;
        end else if (penable) begin
          if (cnt <= 4'd1) begin
            next_state = RESP;
            resp_en    = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The write commits only at the edge that ends RESP, so an abort or a
  // reset taken in WAIT can never leave a partial write behind.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (latch_en) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        cnt     <= WS_LOAD;
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end

      if (resp_en) begin
        pready <= 1'b1;
        if (in_range(resp_addr)) begin
          pslverr <= 1'b0;
          if (!resp_write) prdata <= mem[resp_addr[IDX_W-1:0]];
        end else begin
          pslverr <= 1'b1;
          if (!resp_write) prdata <= '0;
        end
      end else begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end

      if (state == RESP && write_q && in_range(addr_q))
        mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem
//   Three instances of apb_slave_mem with WAIT_STATES = 0, 1 and 3, each on
//   its own bus. Transfers push their expected response onto a scoreboard
//   queue; the entry is popped and compared when pready is observed.
module tb_apb_slave_mem;

  localparam int NDUT = 3;

  logic       pclk = 1'b0;
  logic       presetn [NDUT];
  logic       psel    [NDUT];
  logic       penable [NDUT];
  logic       pwrite  [NDUT];
  logic [7:0] paddr   [NDUT];
  logic [7:0] pwdata  [NDUT];
  logic       pready  [NDUT];
  logic [7:0] prdata  [NDUT];
  logic       pslverr [NDUT];

  int ws [NDUT] = '{0, 1, 3};

  typedef struct {
    string      tag;
    logic       wr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model   [NDUT][64];
  logic [7:0] last_rd [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(1)) u_ws1 (
    .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .presetn(presetn[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel(input int d);
    for (int i = 0; i < 64; i++) model[d][i] = 8'h00;
    last_rd[d] = 8'h00;
  endtask

  task automatic checkOutput(input int d);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_rdy"}, 32'(pready[d]), 32'd1);
    check({e.tag, "_err"}, 32'(pslverr[d]), 32'(e.err));
    if (e.wr) check({e.tag, "_hold"}, 32'(prdata[d]), 32'(last_rd[d]));
    else begin
      check({e.tag, "_data"}, 32'(prdata[d]), 32'(e.data));
      last_rd[d] = e.data;
    end
  endtask

  task automatic applyStimulus(input int d, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, input string tag);
    exp_t e;
    int   cyc;
    bit   seen;
    e.tag  = tag;
    e.wr   = wr;
    e.err  = (addr >= 8'd64);
    e.data = (wr || e.err) ? 8'h00 : model[d][addr[5:0]];
    if (wr && !e.err) model[d][addr[5:0]] = data;
    sb.push_back(e);

    @(posedge pclk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge pclk);
      if (pready[d]) seen = 1'b1;
      else begin
        @(posedge pclk); #1;
        cyc++;
      end
    end
    check({tag, "_lat"}, 32'(cyc), 32'(ws[d] + 1));
    checkOutput(d);
  endtask

  task automatic goIdle(input int d, input string tag);
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge pclk);
    check({tag, "_rdy_lo"}, 32'(pready[d]), 32'd0);
    check({tag, "_err_lo"}, 32'(pslverr[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      presetn[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; paddr[d] = 8'h00; pwdata[d] = 8'h00;
      clearModel(d);
    end
    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < NDUT; d++) presetn[d] = 1'b0;

    // reset state and idle bus
    repeat (3) begin
      @(negedge pclk);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("idle%0d_rdy", d), 32'(pready[d]), 32'd0);
        check($sformatf("idle%0d_rd", d), 32'(prdata[d]), 32'd0);
        check($sformatf("idle%0d_err", d), 32'(pslverr[d]), 32'd0);
      end
    end
    applyStimulus(1, 1'b0, 8'h05, 8'h00, "rst_rd05");
    goIdle(1, "rst_rd05");

    // one wait state write then read
    applyStimulus(1, 1'b1, 8'h10, 8'hA5, "ws1_wr10");
    goIdle(1, "ws1_wr10");
    applyStimulus(1, 1'b0, 8'h10, 8'h00, "ws1_rd10");
    goIdle(1, "ws1_rd10");

    // zero wait states, back-to-back
    applyStimulus(0, 1'b1, 8'h00, 8'h01, "ws0_wr00");
    applyStimulus(0, 1'b1, 8'h01, 8'h02, "ws0_wr01");
    applyStimulus(0, 1'b1, 8'h3F, 8'h03, "ws0_wr3f");
    applyStimulus(0, 1'b0, 8'h00, 8'h00, "ws0_rd00");
    applyStimulus(0, 1'b0, 8'h01, 8'h00, "ws0_rd01");
    applyStimulus(0, 1'b0, 8'h3F, 8'h00, "ws0_rd3f");
    goIdle(0, "ws0_b2b");

    // out of range, then prove mem[0] untouched
    applyStimulus(1, 1'b1, 8'h40, 8'h77, "oor_wr40");
    goIdle(1, "oor_wr40");
    applyStimulus(1, 1'b0, 8'h40, 8'h00, "oor_rd40");
    goIdle(1, "oor_rd40");
    applyStimulus(1, 1'b0, 8'h00, 8'h00, "oor_rd00");
    goIdle(1, "oor_rd00");

    // abort in the 2nd access cycle
    applyStimulus(2, 1'b1, 8'h02, 8'h3C, "ws3_wr02");
    goIdle(2, "ws3_wr02");
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h02; pwdata[2] = 8'hFF;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(negedge pclk);
    check("abort_acc1_rdy", 32'(pready[2]), 32'd0);
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check($sformatf("abort_rdy%0d", i), 32'(pready[2]), 32'd0);
    end
    applyStimulus(2, 1'b0, 8'h02, 8'h00, "abort_rd02");
    goIdle(2, "abort_rd02");

    // reset while a write sits in WAIT
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h03; pwdata[2] = 8'h5A;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(posedge pclk); #1;
    presetn[2] = 1'b1;
    @(posedge pclk); #1;
    presetn[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
    clearModel(2);
    @(negedge pclk);
    check("midrst_rdy", 32'(pready[2]), 32'd0);
    check("midrst_rd", 32'(prdata[2]), 32'd0);
    check("midrst_err", 32'(pslverr[2]), 32'd0);
    applyStimulus(2, 1'b0, 8'h03, 8'h00, "midrst_rd03");
    applyStimulus(2, 1'b0, 8'h02, 8'h00, "midrst_rd02");
    goIdle(2, "midrst_end");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
